// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the range-sweep scheduler and its arbiter.
package counter_sched_pkg;

    localparam int CNT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // A one-requester build still needs a 1-bit pointer.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_range_sweep_sched_rr_arbiter.sv
// Round-robin pick of the first set request at or after ptr, wrapping; purely combinational.
// No state, no backpressure: the caller owns the pointer and decides when to sample.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            vld
);

    logic [NREQ-1:0] ge_mask;
    logic [NREQ-1:0] req_hi;

    always_comb begin
        // Requests at or above the pointer win first; otherwise wrap to the lowest set bit.
        ge_mask = ~((NREQ'(1) << ptr) - NREQ'(1));
        req_hi  = req & ge_mask;
        if (req_hi != '0) begin
            win = req_hi & (~req_hi + NREQ'(1));
        end else begin
            win = req & (~req + NREQ'(1));
        end
        vld = |req;
    end

endmodule

// File: rtl/counter_range_sweep_sched.sv
// Time-shares one range counter between NREQ requesters; load-to-done latency is (last-first)+2.
// req is sampled only in IDLE; SWEEP_TIMEOUT_EN adds a RUN watchdog that ends stuck sweeps with err.
module counter_range_sweep_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] first_i,
    input  logic [NREQ*W-1:0] last_i,
    input  logic [NREQ-1:0]   dir_i,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              busy,
    output logic [W-1:0]      cnt_first,
    output logic [W-1:0]      cnt_last,
    output logic              cnt_load,
    output logic              cnt_u_d,
    input  logic [W-1:0]      cnt_count
);

    localparam int PW = ptr_w(NREQ);

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            err_q, err_d;
    logic [W-1:0]    cnt_first_q, cnt_first_d;
    logic [W-1:0]    cnt_last_q, cnt_last_d;
    logic            cnt_u_d_q, cnt_u_d_d;

    logic [NREQ-1:0] arb_win;
    logic            arb_vld;
    logic [W-1:0]    sel_first;
    logic [W-1:0]    sel_last;
    logic            sel_dir;
    logic [PW-1:0]   ptr_nxt;
    logic [W-1:0]    end_val;

`ifdef SWEEP_TIMEOUT_EN
    logic [W:0]      wd_q, wd_d;
    logic [W:0]      wd_limit;
`endif

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .win (arb_win),
        .vld (arb_vld)
    );

    always_comb begin
        sel_first = '0;
        sel_last  = '0;
        sel_dir   = 1'b0;
        ptr_nxt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_first = sel_first | (first_i[i*W +: W] & {W{arb_win[i]}});
            sel_last  = sel_last  | (last_i[i*W +: W]  & {W{arb_win[i]}});
            sel_dir   = sel_dir   | (dir_i[i] & arb_win[i]);
            if (gnt_q[i]) begin
                ptr_nxt = PW'((i + 1) % NREQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        err_d       = err_q;
        cnt_first_d = cnt_first_q;
        cnt_last_d  = cnt_last_q;
        cnt_u_d_d   = cnt_u_d_q;
        end_val     = cnt_u_d_q ? cnt_last_q : cnt_first_q;
`ifdef SWEEP_TIMEOUT_EN
        wd_d        = wd_q;
        wd_limit    = ({1'b0, cnt_last_q} - {1'b0, cnt_first_q}) + (W+1)'(2);
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    gnt_d       = arb_win;
                    cnt_first_d = sel_first;
                    cnt_last_d  = sel_last;
                    cnt_u_d_d   = sel_dir;
                    // An inverted range is rejected without touching the counter.
                    if (sel_first > sel_last) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
`ifdef SWEEP_TIMEOUT_EN
                wd_d    = (W+1)'(1);
`endif
            end
            ST_RUN: begin
                if (cnt_count == end_val) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                end
`ifdef SWEEP_TIMEOUT_EN
                else if (wd_q >= wd_limit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
                wd_d = wd_q + (W+1)'(1);
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                err_d   = 1'b0;
                ptr_d   = ptr_nxt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            err_q       <= 1'b0;
            cnt_first_q <= '0;
            cnt_last_q  <= '0;
            cnt_u_d_q   <= 1'b1;
`ifdef SWEEP_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            cnt_first_q <= cnt_first_d;
            cnt_last_q  <= cnt_last_d;
            cnt_u_d_q   <= cnt_u_d_d;
`ifdef SWEEP_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = (state_q == ST_DONE) ? gnt_q : '0;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);
    assign cnt_first = cnt_first_q;
    assign cnt_last  = cnt_last_q;
    assign cnt_load  = (state_q == ST_LOAD);
    assign cnt_u_d   = cnt_u_d_q;

endmodule

// File: tb/tb_counter_range_sweep_sched.sv
// Directed bench for counter_range_sweep_sched with a behavioural range counter attached.
module tb_counter_range_sweep_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] first_i = '0;
    logic [NREQ*W-1:0] last_i = '0;
    logic [NREQ-1:0]   dir_i = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              busy;
    logic [W-1:0]      cnt_first;
    logic [W-1:0]      cnt_last;
    logic              cnt_load;
    logic              cnt_u_d;
    logic [W-1:0]      cnt_count;

    logic [W-1:0]      m_cnt = '0;
    bit                stuck = 1'b0;
    int                cyc = 0;
    int                tests = 0;
    int                fails = 0;

    counter_range_sweep_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .first_i   (first_i),
        .last_i    (last_i),
        .dir_i     (dir_i),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .cnt_first (cnt_first),
        .cnt_last  (cnt_last),
        .cnt_load  (cnt_load),
        .cnt_u_d   (cnt_u_d),
        .cnt_count (cnt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running wrap-around range counter, as the shared instance behaves.
    always @(posedge clk) begin
        if (cnt_load)     m_cnt <= cnt_u_d ? cnt_first : cnt_last;
        else if (cnt_u_d) m_cnt <= (m_cnt == cnt_last)  ? cnt_first : m_cnt + 8'd1;
        else              m_cnt <= (m_cnt == cnt_first) ? cnt_last  : m_cnt - 8'd1;
    end
    assign cnt_count = stuck ? 8'd5 : m_cnt;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int idx, input int f, input int l, input bit d);
        first_i[idx*W +: W] = W'(f);
        last_i[idx*W +: W]  = W'(l);
        dir_i[idx]          = d;
    endtask

    // Waits for the grant, checks the LOAD cycle, then follows the sweep to its done pulse.
    task automatic do_sweep(input string tag, input int idx, input int f, input int l,
                            input bit d, input logic [NREQ-1:0] req_after);
        int t0;
        int budget;
        int span;
        bit seen;
        bit bad_hot;
        bit bad_load;
        logic [W-1:0] prev;
        logic [W-1:0] endv;
        span     = l - f;
        endv     = d ? W'(l) : W'(f);
        bad_hot  = 1'b0;
        bad_load = 1'b0;
        seen     = 1'b0;
        budget   = 0;
        while (gnt === '0 && budget < 20) begin
            step();
            budget++;
        end
        chk({tag, "_gnt"}, gnt, 32'(1) << idx);
        chk({tag, "_load"}, cnt_load, 1);
        chk({tag, "_first"}, cnt_first, f);
        chk({tag, "_last"}, cnt_last, l);
        chk({tag, "_ud"}, cnt_u_d, d);
        t0  = cyc;
        req = req_after;
        // Scramble the live config; the latched copy must be what the counter sees.
        set_cfg(idx, l + 40, f, ~d);
        budget = 0;
        prev   = cnt_count;
        while (!seen && budget < span + 20) begin
            prev = cnt_count;
            step();
            budget++;
            if (done !== '0) seen = 1'b1;
            else if (cnt_load !== 1'b0) bad_load = 1'b1;
            if ($countones(gnt) != 1) bad_hot = 1'b1;
        end
        chk({tag, "_done"}, done, 32'(1) << idx);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_latency"}, cyc - t0, span + 2);
        chk({tag, "_endval"}, prev, endv);
        chk({tag, "_gnt_held"}, gnt, 32'(1) << idx);
        chk({tag, "_onehot"}, bad_hot, 0);
        chk({tag, "_single_load"}, bad_load, 0);
        chk({tag, "_first_kept"}, cnt_first, f);
        set_cfg(idx, f, l, d);
        step();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_gnt"}, gnt, 0);
        chk({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        int budget;
        int t0;
        bit seen;

        rst = 1'b0;
        step();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load", cnt_load, 0);
        chk("rst_first", cnt_first, 0);
        chk("rst_last", cnt_last, 0);
        chk("rst_ud", cnt_u_d, 1);
        rst = 1'b1;
        step();

        set_cfg(0, 11, 25, 1'b1);
        req = 4'b0001;
        do_sweep("up11_25", 0, 11, 25, 1'b1, 4'b0000);

        set_cfg(0, 11, 25, 1'b0);
        req = 4'b0001;
        do_sweep("dn11_25", 0, 11, 25, 1'b0, 4'b0000);

        set_cfg(0, 7, 7, 1'b1);
        req = 4'b0001;
        do_sweep("eq7", 0, 7, 7, 1'b1, 4'b0000);

        // Round robin from a freshly reset pointer.
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_cfg(i, 0, 3, 1'b1);
        req = 4'b1111;
        do_sweep("rr0", 0, 0, 3, 1'b1, 4'b1111);
        do_sweep("rr1", 1, 0, 3, 1'b1, 4'b1111);
        do_sweep("rr2", 2, 0, 3, 1'b1, 4'b1111);
        do_sweep("rr3", 3, 0, 3, 1'b1, 4'b1111);
        do_sweep("rr0b", 0, 0, 3, 1'b1, 4'b0000);

        set_cfg(2, 30, 20, 1'b1);
        req = 4'b0100;
        step();
        req = 4'b0000;
        chk("badrange_done", done, 4'b0100);
        chk("badrange_err", err, 1);
        chk("badrange_noload", cnt_load, 0);
        chk("badrange_gnt", gnt, 4'b0100);
        step();
        chk("badrange_idle_done", done, 0);
        chk("badrange_idle_busy", busy, 0);

        // Reset mid-sweep; pointer now sits at 3, so a fresh pointer is visible on req=1001.
        set_cfg(1, 11, 25, 1'b1);
        req = 4'b0010;
        budget = 0;
        while (cnt_count !== 8'd18 || busy !== 1'b1) begin
            step();
            budget++;
            if (budget == 2) req = 4'b0000;
            if (budget > 60) break;
        end
        chk("midrst_reached18", cnt_count, 18);
        rst = 1'b0;
        step();
        chk("midrst_gnt", gnt, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst = 1'b1;
        set_cfg(0, 0, 2, 1'b1);
        set_cfg(3, 0, 2, 1'b1);
        req = 4'b1001;
        do_sweep("post_rst", 0, 0, 2, 1'b1, 4'b0000);

        stuck = 1'b1;
        set_cfg(0, 0, 9, 1'b1);
        req = 4'b0001;
        budget = 0;
        while (cnt_load !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        chk("stuck_load", cnt_load, 1);
        t0  = cyc;
        req = 4'b0000;
        seen = 1'b0;
        budget = 0;
        while (!seen && budget < 40) begin
            step();
            budget++;
            if (done !== '0) seen = 1'b1;
        end
`ifdef SWEEP_TIMEOUT_EN
        chk("timeout_done", done, 4'b0001);
        chk("timeout_err", err, 1);
        chk("timeout_latency", cyc - t0, 12);
`else
        chk("stuck_no_done", seen, 0);
        chk("stuck_busy", busy, 1);
`endif
        rst = 1'b0;
        stuck = 1'b0;
        step();
        chk("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
